// File: rtl/hex_display_pkg.sv
// Shared types and helpers for the multiplexed hex display scheduler.
package hex_display_pkg;

  localparam logic [6:0]  SEG_BLANK  = 7'h7F;
  localparam int unsigned MAX_DIGITS = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  // Digits k>0 whose nibble and every higher-index nibble are zero; digit 0 is never masked.
  function automatic logic [MAX_DIGITS-1:0] lead_zero_mask(input logic [4*MAX_DIGITS-1:0] value,
                                                           input int unsigned             num_digits);
    logic                  zero_above;
    logic [MAX_DIGITS-1:0] mask;
    zero_above = 1'b1;
    mask       = '0;
    for (int k = MAX_DIGITS - 1; k > 0; k--) begin
      if (k < int'(num_digits)) begin
        zero_above = zero_above & (value[4*k +: 4] == 4'h0);
        mask[k]    = zero_above;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/hex_display_scheduler_scan_tick_gen.sv
// Slot timing: tick counter within a digit slot plus slot index, with guard and frame-end strobes.
module scan_tick_gen #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned DIV        = 50000,
  parameter int unsigned GUARD      = 500
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          run,
  output logic [$clog2(NUM_DIGITS)-1:0] slot,
  output logic                          in_guard_c,
  output logic                          frame_end_c
);

  localparam int unsigned TICK_W = $clog2(DIV);
  localparam int unsigned SLOT_W = $clog2(NUM_DIGITS);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              tick_last_c, slot_last_c, slot_adv_c;

  // Counters run only while scanning; otherwise they collapse to slot 0, tick 0.
  always_comb begin
    tick_last_c = (tick_q == TICK_W'(DIV - 1));
    slot_last_c = (slot_q == SLOT_W'(NUM_DIGITS - 1));
    slot_adv_c  = run & tick_last_c;
    tick_d      = '0;
    slot_d      = '0;
    if (run) begin
      tick_d = tick_last_c ? '0 : tick_q + TICK_W'(1);
      slot_d = slot_q;
      if (slot_adv_c) slot_d = slot_last_c ? '0 : slot_q + SLOT_W'(1);
    end
    in_guard_c  = (tick_q < TICK_W'(GUARD));
    frame_end_c = slot_adv_c & slot_last_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
      slot_q <= '0;
    end else begin
      tick_q <= tick_d;
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;

endmodule

// File: rtl/hex_to_7seg.sv
// Hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module hex_to_7seg (
  input  logic [3:0] hex,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = 7'h7F;
    unique case (hex)
      4'h0: seg_c = 7'h40;
      4'h1: seg_c = 7'h79;
      4'h2: seg_c = 7'h24;
      4'h3: seg_c = 7'h30;
      4'h4: seg_c = 7'h19;
      4'h5: seg_c = 7'h12;
      4'h6: seg_c = 7'h02;
      4'h7: seg_c = 7'h78;
      4'h8: seg_c = 7'h00;
      4'h9: seg_c = 7'h10;
      4'hA: seg_c = 7'h08;
      4'hB: seg_c = 7'h03;
      4'hC: seg_c = 7'h46;
      4'hD: seg_c = 7'h21;
      4'hE: seg_c = 7'h06;
      4'hF: seg_c = 7'h0E;
      default: seg_c = 7'h7F;
    endcase
  end

endmodule

// File: rtl/hex_display_scheduler.sv
// Multiplexed common-anode hex display scanner with shadowed loads and per-slot guard band.
// Optional: define HEX_DISPLAY_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module hex_display_scheduler
  import hex_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned DIV        = 50000,
  parameter int unsigned GUARD      = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic [NUM_DIGITS-1:0]   load_blank,
  output logic [NUM_DIGITS-1:0]   digit_n,
  output logic [6:0]              seg,
  output logic                    frame_done
);

  localparam int unsigned SLOT_W = $clog2(NUM_DIGITS);
  localparam int unsigned VAL_W  = 4 * NUM_DIGITS;

  state_e                state_q, state_d;
  logic [VAL_W-1:0]      active_value_q, active_value_d, pend_value_q, pend_value_d;
  logic [NUM_DIGITS-1:0] active_blank_q, active_blank_d, pend_blank_q, pend_blank_d;
  logic                  pending_valid_q, pending_valid_d, loaded_q, loaded_d;
  logic [NUM_DIGITS-1:0] digit_n_q, digit_n_d;
  logic [6:0]            seg_q, seg_d;
  logic                  frame_done_q, frame_done_d, load_ready_q, load_ready_d;

  logic                  run_c, accept_c, in_guard_c, frame_end_c, digit_on_c;
  logic [SLOT_W-1:0]     slot;
  logic [3:0]            nibble_c;
  logic [6:0]            dec_seg_c;
  logic [NUM_DIGITS-1:0] blank_eff_c;

  assign run_c = (state_q == SCAN) & en;

  scan_tick_gen #(
    .NUM_DIGITS (NUM_DIGITS),
    .DIV        (DIV),
    .GUARD      (GUARD)
  ) u_tick (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run_c),
    .slot        (slot),
    .in_guard_c  (in_guard_c),
    .frame_end_c (frame_end_c)
  );

  hex_to_7seg u_dec (
    .hex   (nibble_c),
    .seg_c (dec_seg_c)
  );

`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
  assign blank_eff_c = active_blank_q |
                       NUM_DIGITS'(lead_zero_mask((4*MAX_DIGITS)'(active_value_q), NUM_DIGITS));
`else
  assign blank_eff_c = active_blank_q;
`endif

  always_comb begin
    state_d         = state_q;
    active_value_d  = active_value_q;
    active_blank_d  = active_blank_q;
    pend_value_d    = pend_value_q;
    pend_blank_d    = pend_blank_q;
    pending_valid_d = pending_valid_q;
    loaded_d        = loaded_q;
    accept_c        = load_valid & ~pending_valid_q;

    unique case (state_q)
      IDLE: begin
        // Nothing is on screen, so an accepted load becomes visible directly.
        if (accept_c) begin
          active_value_d = load_value;
          active_blank_d = load_blank;
          loaded_d       = 1'b1;
        end
        if (en & (loaded_q | accept_c)) state_d = SCAN;
      end
      SCAN: begin
        // Visible value only changes on a frame boundary; a load landing exactly there bypasses the shadow.
        if (frame_end_c & pending_valid_q) begin
          active_value_d  = pend_value_q;
          active_blank_d  = pend_blank_q;
          pending_valid_d = 1'b0;
        end else if (frame_end_c & accept_c) begin
          active_value_d = load_value;
          active_blank_d = load_blank;
        end else if (accept_c) begin
          pend_value_d    = load_value;
          pend_blank_d    = load_blank;
          pending_valid_d = 1'b1;
        end
        if (!en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    nibble_c   = active_value_q[{slot, 2'b00} +: 4];
    digit_on_c = run_c & ~in_guard_c & ~blank_eff_c[slot];
    digit_n_d  = '1;
    seg_d      = SEG_BLANK;
    if (digit_on_c) begin
      digit_n_d[slot] = 1'b0;
      seg_d           = dec_seg_c;
    end
    frame_done_d = frame_end_c;
    load_ready_d = ~pending_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      active_value_q  <= '0;
      active_blank_q  <= '0;
      pend_value_q    <= '0;
      pend_blank_q    <= '0;
      pending_valid_q <= 1'b0;
      loaded_q        <= 1'b0;
      digit_n_q       <= '1;
      seg_q           <= SEG_BLANK;
      frame_done_q    <= 1'b0;
      load_ready_q    <= 1'b1;
    end else begin
      state_q         <= state_d;
      active_value_q  <= active_value_d;
      active_blank_q  <= active_blank_d;
      pend_value_q    <= pend_value_d;
      pend_blank_q    <= pend_blank_d;
      pending_valid_q <= pending_valid_d;
      loaded_q        <= loaded_d;
      digit_n_q       <= digit_n_d;
      seg_q           <= seg_d;
      frame_done_q    <= frame_done_d;
      load_ready_q    <= load_ready_d;
    end
  end

  assign digit_n    = digit_n_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;
  assign load_ready = load_ready_q;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Bench for hex_display_scheduler (4 digits, DIV=8, GUARD=2): frame-position reference model feeding
// a scoreboard, plus directed frame captures against literal segment patterns.
module tb_hex_display_scheduler;

  localparam int unsigned ND    = 4;
  localparam int unsigned DV    = 8;
  localparam int unsigned GD    = 2;
  localparam int unsigned FRAME = ND * DV;

  logic        clk = 1'b0;
  logic        rst_n, en, load_valid, load_ready, frame_done;
  logic [15:0] load_value;
  logic [3:0]  load_blank, digit_n;
  logic [6:0]  seg;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] dn;
    logic [6:0] seg;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state: position within the frame instead of separate counters.
  bit          m_scan, m_pvalid, m_loaded;
  int          m_pos;
  logic [15:0] m_active, m_pend;
  logic [3:0]  m_ablank, m_pblank;

  int          low_cnt[ND];
  logic [6:0]  seen_seg[ND];

  always #5 clk = ~clk;

  hex_display_scheduler #(.NUM_DIGITS(ND), .DIV(DV), .GUARD(GD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .load_blank (load_blank),
    .digit_n    (digit_n),
    .seg        (seg),
    .frame_done (frame_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40; 4'h1: s = 7'h79; 4'h2: s = 7'h24; 4'h3: s = 7'h30;
      4'h4: s = 7'h19; 4'h5: s = 7'h12; 4'h6: s = 7'h02; 4'h7: s = 7'h78;
      4'h8: s = 7'h00; 4'h9: s = 7'h10; 4'hA: s = 7'h08; 4'hB: s = 7'h03;
      4'hC: s = 7'h46; 4'hD: s = 7'h21; 4'hE: s = 7'h06; default: s = 7'h0E;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] eff_blank(input logic [15:0] v, input logic [3:0] b);
    logic [3:0] r;
    r = b;
`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
    for (int k = 1; k < ND; k++) if ((v >> (4 * k)) == 16'h0) r[k] = 1'b1;
`endif
    return r;
  endfunction

  // Consumes this edge's inputs, pushes the outputs the DUT must show after the edge.
  task automatic model_step();
    exp_t       e;
    int         slot, tick;
    bit         scan, acc, fe;
    logic [3:0] eb;
    if (!rst_n) begin
      m_scan = 0; m_pos = 0; m_pvalid = 0; m_loaded = 0;
      m_active = '0; m_pend = '0; m_ablank = '0; m_pblank = '0;
      e = '{dn: 4'hF, seg: 7'h7F, fd: 1'b0, rdy: 1'b1};
      sb_q.push_back(e);
      return;
    end
    slot = m_pos / DV;
    tick = m_pos % DV;
    scan = m_scan && en;
    acc  = load_valid && !m_pvalid;
    fe   = scan && (m_pos == FRAME - 1);
    eb   = eff_blank(m_active, m_ablank);
    e.dn  = 4'hF;
    e.seg = 7'h7F;
    if (scan && tick >= GD && !eb[slot]) begin
      e.dn[slot] = 1'b0;
      e.seg      = seg_of(m_active[4*slot +: 4]);
    end
    e.fd = fe;
    if (!m_scan) begin
      if (acc) begin m_active = load_value; m_ablank = load_blank; m_loaded = 1; end
      m_scan = en && m_loaded;
      m_pos  = 0;
    end else begin
      if (fe && m_pvalid) begin
        m_active = m_pend; m_ablank = m_pblank; m_pvalid = 0;
      end else if (fe && acc) begin
        m_active = load_value; m_ablank = load_blank;
      end else if (acc) begin
        m_pend = load_value; m_pblank = load_blank; m_pvalid = 1;
      end
      m_pos  = scan ? (m_pos + 1) % FRAME : 0;
      m_scan = en;
    end
    e.rdy = !m_pvalid;
    sb_q.push_back(e);
  endtask

  // Scoreboard: model at the active edge, compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_eq("sb_digit_n", 32'(digit_n), 32'(e.dn));
        check_eq("sb_seg", 32'(seg), 32'(e.seg));
        check_eq("sb_frame_done", 32'(frame_done), 32'(e.fd));
        check_eq("sb_load_ready", 32'(load_ready), 32'(e.rdy));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] b);
    int waited;
    bit done;
    waited = 0;
    done   = 0;
    load_value = v;
    load_blank = b;
    load_valid = 1'b1;
    while (!done && waited < 200) begin
      if (load_ready) done = 1;
      @(negedge clk);
      waited++;
    end
    load_valid = 1'b0;
    check_eq("load_accept", 32'(done), 32'd1);
  endtask

  task automatic wait_fd(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 200);
    check_eq("fd_seen", 32'(frame_done), 32'd1);
  endtask

  // Skips to the next frame boundary, then records which digits light and with what pattern.
  task automatic scan_frame();
    int n;
    wait_fd(n);
    for (int k = 0; k < ND; k++) begin low_cnt[k] = 0; seen_seg[k] = 7'h7F; end
    repeat (FRAME) begin
      @(negedge clk);
      for (int k = 0; k < ND; k++) if (digit_n[k] == 1'b0) begin
        low_cnt[k]++;
        seen_seg[k] = seg;
      end
    end
  endtask

  task automatic check_frame(input string tag, input logic [27:0] segs, input logic [3:0] blank);
    for (int k = 0; k < ND; k++) begin
      check_eq($sformatf("%s_low%0d", tag, k), 32'(low_cnt[k]), blank[k] ? 32'd0 : 32'(DV - GD));
      if (!blank[k]) check_eq($sformatf("%s_seg%0d", tag, k), 32'(seen_seg[k]), 32'(segs[7*k +: 7]));
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; en = 1'b0; load_valid = 1'b0; load_value = '0; load_blank = '0;
    cycles(2);
    check_eq("rst_digit_n", 32'(digit_n), 32'hF);
    check_eq("rst_seg", 32'(seg), 32'h7F);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);
    check_eq("rst_load_ready", 32'(load_ready), 32'd1);
    #1 rst_n = 1'b1;
    cycles(1);
    en = 1'b1;

    load(16'h1A3F, 4'b0000);
    scan_frame();
    check_frame("f1", {7'h79, 7'h08, 7'h30, 7'h0E}, 4'b0000);
    wait_fd(n);
    check_eq("fd_period", 32'(n), 32'(FRAME));

    cycles(5);
    load(16'h5678, 4'b0000);
    check_eq("ready_drop", 32'(load_ready), 32'd0);
    wait_fd(n);
    check_eq("ready_back", 32'(load_ready), 32'd1);
    scan_frame();
    check_frame("f2", {7'h12, 7'h02, 7'h78, 7'h00}, 4'b0000);

    // Offer a value only during the frame-end cycle.
    cycles(FRAME - 1);
    load_value = 16'h9BCE; load_blank = 4'b0000; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    check_eq("fe_ready", 32'(load_ready), 32'd1);
    scan_frame();
    check_frame("f3", {7'h10, 7'h03, 7'h46, 7'h06}, 4'b0000);

    load(16'h1A3F, 4'b0101);
    scan_frame();
    check_frame("f4", {7'h79, 7'h08, 7'h30, 7'h0E}, 4'b0101);

    cycles(11);
    check_eq("pre_off_dn", 32'(digit_n), 32'hD);
    en = 1'b0;
    cycles(1);
    check_eq("off_digit_n", 32'(digit_n), 32'hF);
    check_eq("off_seg", 32'(seg), 32'h7F);
    cycles(3);
    en = 1'b1;
    wait_fd(n);
    check_eq("restart_fd", 32'(n), 32'(FRAME + 1));

    cycles(12);
    load(16'h2222, 4'b0000);
    check_eq("pend_full", 32'(load_ready), 32'd0);
    check_eq("pre_rst_dn", 32'(digit_n), 32'hD);
    #1 rst_n = 1'b0;
    #1;
    check_eq("arst_digit_n", 32'(digit_n), 32'hF);
    check_eq("arst_seg", 32'(seg), 32'h7F);
    check_eq("arst_load_ready", 32'(load_ready), 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    cycles(40);
    check_eq("idle_digit_n", 32'(digit_n), 32'hF);

    load(16'h0040, 4'b0000);
    scan_frame();
`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
    check_frame("lz", {7'h7F, 7'h7F, 7'h19, 7'h40}, 4'b1100);
    load(16'h0000, 4'b0000);
    scan_frame();
    check_frame("lz0", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1110);
`else
    check_frame("nolz", {7'h40, 7'h40, 7'h19, 7'h40}, 4'b0000);
`endif

    cycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex_display_scheduler.md
Name: hex_display_scheduler

Overview:
- Time-multiplexes one shared hex_to_7seg decoder across NUM_DIGITS common-anode seven-segment digits.
- Cycles a digit-select strobe and drives the active digit's nibble through the decoder.
- Inserts an anti-ghosting guard band in every digit slot.
- Takes new display values over a valid/ready handshake into a shadow register. The visible value only changes at a frame boundary.

Parameters:
- NUM_DIGITS, 6, number of digit slots scanned (≥2).
- DIV, 50000, clk cycles per digit slot (≥GUARD+2).
- GUARD, 500, cycles at the start of each slot with all digits off.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable.
- load_valid  in  1  new value offered.
- load_ready  out  1  shadow register empty; load accepted on load_valid & load_ready.
- load_value  in  4*NUM_DIGITS  nibble k drives digit k (bits [4k+3:4k]).
- load_blank  in  NUM_DIGITS  bit k=1 blanks digit k.
- digit_n  out  NUM_DIGITS  active-low digit select; at most one bit low.
- seg  out  7  active-low segments {g,f,e,d,c,b,a}, from hex_to_7seg.
- frame_done  out  1  one-cycle pulse at the last cycle of each frame.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; tick_cnt=0, slot=0.
  - active/pending value and blank registers cleared; pending_valid=0.
  - Outputs: digit_n=all 1, seg=7'h7F, frame_done=0, load_ready=1.
- States:
  - IDLE: outputs blank, counters held at 0.
    - IDLE→SCAN on the first accepted load while en=1.
    - The accepted value goes straight to the active registers.
  - SCAN: tick_cnt counts 0..DIV-1. On DIV-1 it wraps, and slot advances (NUM_DIGITS-1 wraps to 0).
    - Frame end = SCAN & slot==NUM_DIGITS-1 & tick_cnt==DIV-1; frame_done is registered from it (high the following cycle).
    - SCAN→IDLE immediately when en=0: counters to 0, outputs blank next cycle.
    - Active and pending contents are retained.
    - When en rises again, return to SCAN if the active value was ever loaded.
- Handshake:
  - load_ready = ~pending_valid.
  - An accept in SCAN writes pending and sets pending_valid.
  - At frame end with pending_valid=1: pending copies to active, and pending_valid clears (ready high next cycle).
  - Accept in the same cycle as frame end (pending empty): the value bypasses to active, and pending stays empty.
  - load_valid with load_ready=0 is ignored. The source must hold the value until accepted.
- Outputs, registered, one cycle after the counter state that produces them:
  - digit_n[k]=0 iff SCAN & slot==k & tick_cnt≥GUARD & active_blank[k]=0.
  - seg = hex_to_7seg(active nibble[slot]) under the same condition, else 7'h7F.
- Widths:
  - tick_cnt is $clog2(DIV) bits.
  - slot is $clog2(NUM_DIGITS) bits.
  - No value beyond DIV-1 or NUM_DIGITS-1 is ever reached.
- Reset mid-frame clears everything, including any un-transferred pending value.

Optional Feature:
- Macro HEX_DISPLAY_LEADING_ZERO_BLANK_EN.
- Defined:
  - A digit is also blanked when its nibble and every higher-index nibble are 0.
  - Digit 0 is never blanked by this rule, so 0 shows as "0".
  - The rule is evaluated on the active registers and ORed with active_blank.
- Undefined: only load_blank controls blanking.

Decomposition:
- Package hex_display_pkg:
  - SEG_BLANK=7'h7F.
  - State enum {IDLE, SCAN}.
  - Helper function for the leading-zero mask.
- Sub-modules:
  - scan_tick_gen: DIV/GUARD counter producing slot_adv, in_guard and frame_end strobes.
  - Existing hex_to_7seg, instantiated once, unchanged.

Test Plan (NUM_DIGITS=4, DIV=8, GUARD=2):
- Reset, then load 16'h1A3F, blank=0 → frames show digit0 seg=7'h0E, digit1 7'h30, digit2 7'h08, digit3 7'h79.
  - Each digit is low 6 of 8 cycles; all digits high for 2 guard cycles per slot.
  - frame_done pulses every 32 cycles.
- Second load mid-frame → load_ready drops next cycle; display unchanged until frame_done; new value visible from the next slot 0; load_ready high again.
- load_valid held asserted during frame-end cycle with pending empty → accepted, shown from the next frame, load_ready stays 1.
- blank=4'b0101 → digit_n[0] and [2] never low, seg=7'h7F in those slots.
- en=0 mid-slot → next cycle digit_n=4'hF, seg=7'h7F.
  - en=1 → scan restarts at slot 0, tick 0, with the old value.
- rst_n pulse mid-frame with pending full → outputs blank asynchronously; load_ready=1; IDLE until a new load.
- With HEX_DISPLAY_LEADING_ZERO_BLANK_EN, load 16'h0040 → digits 3 and 2 blanked, digit1 7'h19, digit0 7'h40.
  - Load 16'h0000 → only digit0 shows 7'h40.
